// File: rtl/regfile_wb_arbiter_if.sv
// Write-port bus between the pipeline/long-latency requesters and the register file arbiter.
// Ports: wb_* (pipeline writeback request), lu_* (long-latency unit request + lu_ready),
//        pipe_stall/init_busy (pipeline control), rf_* (register file write port).
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            wb_valid;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            lu_valid;
    logic [AW-1:0]   lu_rd;
    logic [XLEN-1:0] lu_data;
    logic            lu_ready;
    logic            pipe_stall;
    logic            init_busy;
    logic            rf_we;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_wdata;

    // Requester side: pipeline WB stage and long-latency unit.
    modport master (
        output wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
        input  lu_ready, pipe_stall, init_busy, rf_we, rf_rd, rf_wdata
    );

    // Arbiter side.
    modport slave (
        input  wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
        output lu_ready, pipe_stall, init_busy, rf_we, rf_rd, rf_wdata
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Purpose: owns the register file write port; clears x1..x(NREG-1) after reset, then
//          arbitrates pipeline WB (priority) against a long-latency unit with anti-starvation.
// Latency: combinational grant/write in the request cycle; clear takes NREG-1 cycles.
// Backpressure: lu held via lu_ready=0; pipeline frozen via pipe_stall (init and forced lu grant).
// Ports: clk_i, rst_i (sync, active-high), bus (slave modport of regfile_wb_arbiter_if).
module regfile_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int NREG         = 32,
    parameter int AW           = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] init_cnt_q, init_cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [SW-1:0] starve_inc;
    logic          wb_req;
    logic          lu_blocked;

    // A writeback to x0 is dropped and never takes the port.
    assign wb_req     = bus.wb_valid && (bus.wb_rd != '0);
    // In RUN the lu only loses when wb owns the port and the lu write is a real one;
    // x0 lu writes are always accepted and discarded.
    assign lu_blocked = bus.lu_valid && wb_req && (bus.lu_rd != '0);
    assign starve_inc = starve_q + SW'(1);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_INIT;
            init_cnt_q <= AW'(1);
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            starve_q   <= starve_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        starve_d   = starve_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + AW'(1);
                if (init_cnt_q == AW'(NREG - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (lu_blocked) begin
                    if (starve_inc == SW'(STARVE_LIMIT)) begin
                        state_d  = ST_FORCE;
                        starve_d = '0;
                    end else begin
                        starve_d = starve_inc;
                    end
                end else begin
                    starve_d = '0;
                end
            end
            ST_FORCE: begin
                // Single forced-grant cycle; WB replays its held request next cycle.
                state_d  = ST_RUN;
                starve_d = '0;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Output logic: reset overrides everything so no lu transfer can land during rst.
    always_comb begin
        bus.rf_we      = 1'b0;
        bus.rf_rd      = '0;
        bus.rf_wdata   = XLEN'(0);
        bus.lu_ready   = 1'b0;
        bus.pipe_stall = 1'b1;
        bus.init_busy  = 1'b1;
        if (!rst_i) begin
            case (state_q)
                ST_INIT: begin
                    bus.rf_we = 1'b1;
                    bus.rf_rd = init_cnt_q;
                end
                ST_RUN: begin
                    bus.pipe_stall = 1'b0;
                    bus.init_busy  = 1'b0;
                    if (wb_req) begin
                        bus.rf_we    = 1'b1;
                        bus.rf_rd    = bus.wb_rd;
                        bus.rf_wdata = bus.wb_data;
                        bus.lu_ready = bus.lu_valid && (bus.lu_rd == '0);
                    end else if (bus.lu_valid) begin
                        bus.lu_ready = 1'b1;
                        bus.rf_we    = (bus.lu_rd != '0);
                        bus.rf_rd    = bus.lu_rd;
                        bus.rf_wdata = bus.lu_data;
                    end
                end
                ST_FORCE: begin
                    bus.init_busy = 1'b0;
                    if (bus.lu_valid) begin
                        bus.lu_ready = 1'b1;
                        bus.rf_we    = (bus.lu_rd != '0);
                        bus.rf_rd    = bus.lu_rd;
                        bus.rf_wdata = bus.lu_data;
                    end
                end
                default: begin
                    bus.rf_we = 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: the driver pushes the expected outputs for each
// cycle's stimulus; a monitor pops and compares them mid-cycle, away from the clock edge.
// Ports: none (top-level bench).
module tb_regfile_wb_arbiter;
    logic clk_i;
    logic rst_i;

    regfile_wb_arbiter_if #(.XLEN(32), .AW(5)) bus ();

    regfile_wb_arbiter #(
        .XLEN(32), .NREG(32), .AW(5), .STARVE_LIMIT(4)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b1;
    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        lu_ready;
        logic        stall;
        logic        busy;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc_n = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic we, input logic [4:0] rd, input logic [31:0] data,
                                input logic lrdy, input logic stall, input logic busy);
        exp_t e;
        e.we = we; e.rd = rd; e.data = data;
        e.lu_ready = lrdy; e.stall = stall; e.busy = busy;
        return e;
    endfunction

    // Drive one cycle of stimulus at the falling edge and queue its expected outputs.
    task automatic drv(input logic r,
                       input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                       input exp_t e);
        @(negedge clk_i);
        rst_i        = r;
        bus.wb_valid = wv;
        bus.wb_rd    = wr;
        bus.wb_data  = wd;
        bus.lu_valid = lv;
        bus.lu_rd    = lr;
        bus.lu_data  = ld;
        sb_q.push_back(e);
    endtask

    // Monitor: compare 3 time units after the falling edge, well before the rising edge.
    always @(negedge clk_i) begin
        exp_t e;
        #3;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            cyc_n++;
            chk($sformatf("c%0d_we", cyc_n), {31'd0, bus.rf_we}, {31'd0, e.we});
            chk($sformatf("c%0d_lu_ready", cyc_n), {31'd0, bus.lu_ready}, {31'd0, e.lu_ready});
            chk($sformatf("c%0d_stall", cyc_n), {31'd0, bus.pipe_stall}, {31'd0, e.stall});
            chk($sformatf("c%0d_busy", cyc_n), {31'd0, bus.init_busy}, {31'd0, e.busy});
            if (e.we) begin
                chk($sformatf("c%0d_rd", cyc_n), {27'd0, bus.rf_rd}, {27'd0, e.rd});
                chk($sformatf("c%0d_wdata", cyc_n), bus.rf_wdata, e.data);
            end
        end
    end

    localparam logic [31:0] WD3 = 32'h0000_0333;
    localparam logic [31:0] LD9 = 32'h0000_0999;

    initial begin
        rst_i        = 1'b1;
        bus.wb_valid = 1'b0;
        bus.wb_rd    = '0;
        bus.wb_data  = '0;
        bus.lu_valid = 1'b0;
        bus.lu_rd    = '0;
        bus.lu_data  = '0;

        // Reset: everything blocked even with requests present.
        repeat (2) drv(1, 1, 5'd5, 32'h1111, 1, 5'd9, LD9, mk(0, 0, 0, 0, 1, 1));

        // Clear sequence x1..x31; pipeline request ignored.
        for (int i = 1; i <= 31; i++)
            drv(0, 1, 5'd5, 32'hAAAA, 0, 0, 0, mk(1, 5'(i), 0, 0, 1, 1));

        // Cycle 32: RUN, idle.
        drv(0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0));
        // WB write and dropped x0 WB.
        drv(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, mk(1, 5'd5, 32'hDEADBEEF, 0, 0, 0));
        drv(0, 1, 5'd0, 32'h5555, 0, 0, 0, mk(0, 0, 0, 0, 0, 0));
        // Lone lu write.
        drv(0, 0, 0, 0, 1, 5'd7, 32'h1234, mk(1, 5'd7, 32'h1234, 1, 0, 0));

        // Starvation: 4 blocked cycles, forced grant, then WB replay.
        for (int k = 0; k < 4; k++)
            drv(0, 1, 5'd3, WD3, 1, 5'd9, LD9, mk(1, 5'd3, WD3, 0, 0, 0));
        drv(0, 1, 5'd3, WD3, 1, 5'd9, LD9, mk(1, 5'd9, LD9, 1, 1, 0));
        drv(0, 1, 5'd3, WD3, 0, 0, 0, mk(1, 5'd3, WD3, 0, 0, 0));

        // x0 lu write accepted alongside busy WB, and alone (no write).
        drv(0, 1, 5'd3, WD3, 1, 5'd0, 32'h77, mk(1, 5'd3, WD3, 1, 0, 0));
        drv(0, 0, 0, 0, 1, 5'd0, 32'h77, mk(0, 0, 0, 1, 0, 0));

        // Counter clears on transfer: 2 blocked, granted on WB idle, new request needs full 4.
        repeat (2) drv(0, 1, 5'd3, WD3, 1, 5'd9, LD9, mk(1, 5'd3, WD3, 0, 0, 0));
        drv(0, 0, 0, 0, 1, 5'd9, LD9, mk(1, 5'd9, LD9, 1, 0, 0));
        for (int k = 0; k < 4; k++)
            drv(0, 1, 5'd3, WD3, 1, 5'd10, 32'hA0, mk(1, 5'd3, WD3, 0, 0, 0));
        drv(0, 1, 5'd3, WD3, 1, 5'd10, 32'hA0, mk(1, 5'd10, 32'hA0, 1, 1, 0));

        // FORCE with lu_valid dropped: no write, no grant, still back to RUN.
        for (int k = 0; k < 4; k++)
            drv(0, 1, 5'd3, WD3, 1, 5'd11, 32'hB0, mk(1, 5'd3, WD3, 0, 0, 0));
        drv(0, 1, 5'd3, WD3, 0, 0, 0, mk(0, 0, 0, 0, 1, 0));
        drv(0, 1, 5'd3, WD3, 0, 0, 0, mk(1, 5'd3, WD3, 0, 0, 0));

        // Reset during the starve count: lu never lands, clear restarts at x1.
        for (int k = 0; k < 3; k++)
            drv(0, 1, 5'd3, WD3, 1, 5'd12, 32'hC0, mk(1, 5'd3, WD3, 0, 0, 0));
        drv(1, 1, 5'd3, WD3, 1, 5'd12, 32'hC0, mk(0, 0, 0, 0, 1, 1));
        for (int i = 1; i <= 31; i++)
            drv(0, 1, 5'd3, WD3, 1, 5'd12, 32'hC0, mk(1, 5'(i), 0, 0, 1, 1));
        // Starve counter restarted from zero: full 4 blocked cycles before FORCE.
        for (int k = 0; k < 4; k++)
            drv(0, 1, 5'd3, WD3, 1, 5'd12, 32'hC0, mk(1, 5'd3, WD3, 0, 0, 0));
        drv(0, 1, 5'd3, WD3, 1, 5'd12, 32'hC0, mk(1, 5'd12, 32'hC0, 1, 1, 0));
        drv(0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0));

        // Let the monitor drain the last entry.
        @(negedge clk_i);
        #4;
        chk("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
